// File: rtl/data_ram_responder.sv
// Byte-wide data RAM answering core load/store/push/pop with a fixed number of wait states.
// Optional RAM_ERR_EN: flags and suppresses accesses whose latched address exceeds the depth.
module data_ram_responder #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_addr,
    input  logic [7:0]  i_wdata,
    input  logic        i_read,
    input  logic        i_write,
    output logic [7:0]  o_rdata,
    output logic        o_done,
    output logic        o_busy,
    output logic        o_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W = (WAIT_CYCLES == 0) ? 1 : $clog2(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state, w_state_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic [15:0]        r_addr;
    logic [7:0]         r_wdata;
    logic               r_is_write;
    logic               r_both;
    logic [7:0]         r_rdata;
    logic               r_done;
    logic               r_busy;
    logic               r_err;
    logic [7:0]         r_mem [DEPTH];

    logic               w_capture;
    logic               w_enter_done;
    logic               w_oor;
    logic               w_err;
    logic               w_mem_we;
    logic [ADDR_WIDTH-1:0] w_idx;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        w_enter_done = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_read || i_write) begin
                    w_capture    = 1'b1;
                    w_cnt_next   = CNT_W'(WAIT_CYCLES);
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    w_enter_done = 1'b1;
                    w_state_next = S_DONE;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

`ifdef RAM_ERR_EN
    assign w_oor = ((32'(r_addr) >> ADDR_WIDTH) != 32'd0);
`else
    assign w_oor = 1'b0;
`endif

    assign w_idx    = r_addr[ADDR_WIDTH-1:0];
    assign w_err    = r_both | w_oor;
    assign w_mem_we = w_enter_done & r_is_write & ~w_oor;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
            r_both     <= 1'b0;
            r_rdata    <= 8'h00;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_done  <= w_enter_done;
            r_busy  <= (w_state_next != S_IDLE);
            r_err   <= w_enter_done & w_err;
            if (w_capture) begin
                r_addr     <= i_addr;
                r_wdata    <= i_wdata;
                // A simultaneous read/write is serviced as a write.
                r_is_write <= i_write;
                r_both     <= i_read & i_write;
            end
            if (w_enter_done && !r_is_write) begin
                r_rdata <= w_oor ? 8'h00 : r_mem[w_idx];
            end
        end
    end

    // Storage is not reset; the reset term only blocks a commit racing an asserted reset.
    always_ff @(posedge i_clk) begin
        if (w_mem_we && !i_rst) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    assign o_rdata = r_rdata;
    assign o_done  = r_done;
    assign o_busy  = r_busy;
    assign o_err   = r_err;

endmodule

// File: tb/tb_data_ram_responder.sv
// Self-checking bench for data_ram_responder: directed table, corner sequences, random traffic.
// Expectations follow RAM_ERR_EN when the build defines it.
module tb_data_ram_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned W     = 2;
`ifdef RAM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [15:0] i_addr = '0;
    logic [7:0]  i_wdata = '0;
    logic        i_read = 1'b0;
    logic        i_write = 1'b0;
    logic [7:0]  o_rdata;
    logic        o_done, o_busy, o_err;

    logic        s_read = 1'b0;
    logic [7:0]  w0_rdata, w5_rdata;
    logic        w0_done, w0_busy, w0_err, w5_done, w5_busy, w5_err;

    always #5 i_clk = ~i_clk;

    data_ram_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(W)) u_dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_read(i_read), .i_write(i_write), .o_rdata(o_rdata), .o_done(o_done),
        .o_busy(o_busy), .o_err(o_err)
    );
    data_ram_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) u_w0 (
        .i_clk(i_clk), .i_rst(i_rst), .i_addr(16'h0000), .i_wdata(8'h00),
        .i_read(s_read), .i_write(1'b0), .o_rdata(w0_rdata), .o_done(w0_done),
        .o_busy(w0_busy), .o_err(w0_err)
    );
    data_ram_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(5)) u_w5 (
        .i_clk(i_clk), .i_rst(i_rst), .i_addr(16'h0000), .i_wdata(8'h00),
        .i_read(s_read), .i_write(1'b0), .o_rdata(w5_rdata), .o_done(w5_done),
        .o_busy(w5_busy), .o_err(w5_err)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: byte array plus the byte the core last got back.
    logic [7:0] model_mem [DEPTH];
    logic [7:0] model_rdata = 8'h00;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic do_op(input bit rd, input bit wr, input logic [15:0] a, input logic [7:0] d,
                         output logic [7:0] got_rdata, output logic got_err);
        int  lat;
        bit  seen;
        bit  oor;
        logic [7:0] exp_rdata;
        @(negedge i_clk);
        i_read = rd; i_write = wr; i_addr = a; i_wdata = d;
        lat = 0; seen = 0;
        while (!seen && lat < 40) begin
            @(negedge i_clk);
            lat++;
            if (lat == 1) begin
                i_read = 1'b0; i_write = 1'b0;
                i_addr = 16'($urandom); i_wdata = 8'($urandom);
                chk("busy_c1", 32'(o_busy), 32'd1);
                chk("rdata_held", 32'(o_rdata), 32'(model_rdata));
            end
            if (o_done) seen = 1;
        end
        chk("latency", lat, W + 2);
        got_rdata = o_rdata;
        got_err   = o_err;
        oor = ERR_EN && (32'(a) >= DEPTH);
        if (wr) begin
            if (!oor) model_mem[a % DEPTH] = d;
        end else begin
            model_rdata = oor ? 8'h00 : model_mem[a % DEPTH];
        end
        exp_rdata = model_rdata;
        chk("rdata", 32'(got_rdata), 32'(exp_rdata));
        chk("err", 32'(got_err), 32'((rd && wr) || oor));
        @(negedge i_clk);
        chk("done_width", 32'(o_done), 32'd0);
        chk("busy_after", 32'(o_busy), 32'd0);
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
        bit          exp_err;
    } vec_t;

    initial begin
        vec_t       tbl [7];
        logic [7:0] rdv;
        logic       erv;
        int         cnt, dc0, dc5, dn0, dn5, lat;
        bit         seen;

        #1;
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_rdata", 32'(o_rdata), 32'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;

        // Latency sweep on the WAIT_CYCLES=0 and =5 instances.
        @(negedge i_clk);
        s_read = 1'b1;
        dc0 = 0; dc5 = 0; dn0 = 0; dn5 = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge i_clk);
            if (c == 1) begin
                s_read = 1'b0;
                chk("w0_busy_c1", 32'(w0_busy), 32'd1);
                chk("w5_busy_c1", 32'(w5_busy), 32'd1);
            end
            if (w0_done) begin dn0++; dc0 = c; chk("w0_busy_done", 32'(w0_busy), 32'd1); end
            if (w5_done) begin dn5++; dc5 = c; chk("w5_busy_done", 32'(w5_busy), 32'd1); end
        end
        chk("w0_latency", dc0, 2);
        chk("w5_latency", dc5, 7);
        chk("w0_done_count", dn0, 1);
        chk("w5_done_count", dn5, 1);

        for (int a = 0; a < int'(DEPTH); a++) begin
            do_op(1'b0, 1'b1, 16'(a), 8'($urandom), rdv, erv);
        end

        tbl[0] = '{1'b0, 1'b1, 16'h0005, 8'hA5, 8'h00, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 16'h0005, 8'h00, 8'hA5, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 16'h0010, 8'h77, 8'hA5, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 16'h0010, 8'h00, 8'h77, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 16'h0105, 8'h3C, 8'h77, ERR_EN};
        tbl[5] = '{1'b1, 1'b0, 16'h0005, 8'h00, ERR_EN ? 8'hA5 : 8'h3C, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 16'h0105, 8'h00, ERR_EN ? 8'h00 : 8'h3C, ERR_EN};
        for (int i = 0; i < 7; i++) begin
            do_op(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, rdv, erv);
            chk($sformatf("tbl%0d_rdata", i), 32'(rdv), 32'(tbl[i].exp_rdata));
            chk($sformatf("tbl%0d_err", i), 32'(erv), 32'(tbl[i].exp_err));
        end

        // Read strobe held through the done cycle; only one completion may follow.
        @(negedge i_clk);
        i_read = 1'b1; i_addr = 16'h0010;
        lat = 0; seen = 0;
        while (!seen && lat < 40) begin
            @(negedge i_clk);
            lat++;
            if (o_done) seen = 1;
        end
        chk("hold_latency", lat, W + 2);
        chk("hold_rdata", 32'(o_rdata), 32'h77);
        model_rdata = 8'h77;
        @(posedge i_clk);
        #1 i_read = 1'b0;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge i_clk);
            if (o_done || o_busy) cnt++;
        end
        chk("hold_no_recapture", cnt, 0);

        // Reset during the busy phase of a write must drop the write.
        @(negedge i_clk);
        i_write = 1'b1; i_addr = 16'h0020; i_wdata = 8'hFF;
        @(negedge i_clk);
        i_write = 1'b0;
        @(negedge i_clk);
        chk("mid_busy", 32'(o_busy), 32'd1);
        i_rst = 1'b1;
        #1;
        chk("mid_rst_done", 32'(o_done), 32'd0);
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        chk("mid_rst_err", 32'(o_err), 32'd0);
        chk("mid_rst_rdata", 32'(o_rdata), 32'd0);
        model_rdata = 8'h00;
        @(negedge i_clk);
        i_rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge i_clk);
            if (o_done) cnt++;
        end
        chk("mid_rst_no_done", cnt, 0);
        do_op(1'b1, 1'b0, 16'h0020, 8'h00, rdv, erv);

        for (int i = 0; i < 300; i++) begin
            int unsigned k;
            logic [15:0] a;
            k = $urandom_range(0, 9);
            a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
            do_op(k <= 3 || k == 9, k >= 4, a, 8'($urandom), rdv, erv);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/data_ram_responder.md
# data_ram_responder

Byte-wide data RAM that answers the processor core's load/store/push/pop traffic. It samples a read or write strobe together with a 16-bit address. It then inserts a configurable number of wait states and pulses a one-cycle done. For reads it holds the returned byte stable until the next read completes. It sits between the core's data-memory port and the on-chip storage array, in place of a testbench memory model.

## Interface
- ADDR_WIDTH, 8, number of implemented address bits; depth is 2**ADDR_WIDTH bytes
- WAIT_CYCLES, 2, extra wait states inserted between request capture and done (0 allowed)
- i_clk  input  1  clock, rising-edge
- i_rst  input  1  reset, asynchronous, active-high
- i_addr  input  16  byte address from core
- i_wdata  input  8  write data, valid with i_write
- i_read  input  1  read strobe (LD, POP)
- i_write  input  1  write strobe (ST, PUSH)
- o_rdata  output  8  read data, valid from o_done cycle until the next read's o_done
- o_done  output  1  one-cycle completion pulse
- o_busy  output  1  high while a request is in flight (S_BUSY or S_DONE)
- o_err  output  1  error qualifier, valid only while o_done=1

## Operation
- States: S_IDLE, S_BUSY, S_DONE; 2-bit state register plus counter of width clog2(WAIT_CYCLES+1) (min 1).
- S_IDLE: at a clock edge with i_read|i_write high, latch i_addr, i_wdata and the operation. Load the counter with WAIT_CYCLES, then go to S_BUSY. No strobe: stay.
- S_BUSY: counter==0 → S_DONE, else decrement. Strobe changes are ignored; latched copies are used.
- Entry into S_DONE (same edge): a write commits mem[addr] <= wdata; a read loads o_rdata <= mem[addr].
- S_DONE: o_done=1 for exactly one cycle, then S_IDLE unconditionally. Strobes still high during S_DONE are not re-captured. The core drops them the following cycle.
- i_read and i_write both high at capture: treated as write; o_err=1 on the done pulse.
- Address index is latched addr[ADDR_WIDTH-1:0].
- o_rdata is unchanged by writes and by erroneous reads unless stated below.
- The memory array is not reset.

## Timing
- Reset values: state S_IDLE, o_done=0, o_busy=0, o_err=0, o_rdata=8'h00, counter=0.
- Request high in cycle 0 is captured at the end of cycle 0. o_done is high in cycle WAIT_CYCLES+2, giving 4 cycles with the default.
- o_done, o_err, o_busy and o_rdata are registered; there are no combinational input→output paths.
- Minimum spacing: a new request can be captured at the earliest in the cycle after o_done. Back-to-back throughput is one access per WAIT_CYCLES+3 cycles.
- Reset asserted mid-operation: immediate return to S_IDLE with outputs at reset values. A pending write is dropped and the memory is unchanged.

## Configuration
- RAM_ERR_EN defined:
  - Latched addresses >= 2**ADDR_WIDTH are out of range.
  - An out-of-range write is discarded.
  - An out-of-range read loads o_rdata=8'h00.
  - Both raise o_err with o_done.
- RAM_ERR_EN undefined:
  - The address is silently truncated, so it wraps modulo depth.
  - o_err is high only for the simultaneous read/write case.

## Test plan
- Write then read: write addr 16'h0005 data 8'hA5, then read 16'h0005. Expect o_done in cycle 4 after each strobe and o_rdata=8'hA5 held until the next read's done, with o_err=0.
- Latency sweep: WAIT_CYCLES=0 and 5 → o_done in cycle 2 and cycle 7 respectively. o_done is exactly one cycle wide and o_busy is high from cycle 1 through the done cycle.
- Strobe held through done: i_read held high until the cycle after o_done → only one o_done is observed and there is no second capture.
- Out of range, ADDR_WIDTH=8:
  - With RAM_ERR_EN: write 16'h0105=8'h3C, then read 16'h0005 → old value. Reading 16'h0105 → o_rdata=8'h00, o_err=1.
  - Without RAM_ERR_EN: the same write makes a read of 16'h0005 return 8'h3C, with o_err=0.
- Simultaneous strobes: i_read=i_write=1, addr 16'h0010, wdata 8'h77 → on done, o_err=1 and mem[16'h10] becomes 8'h77. A later read returns 8'h77.
- Reset mid-operation: assert i_rst in S_BUSY of a write of 8'hFF to 16'h0020 → no o_done, outputs at reset values, and a read of 16'h0020 after reset returns its prior contents.
